// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the UART MMIO blocks: register offsets, STATUS/CTRL bit
// positions, DATA word layout and the bus FSM state encoding.
package uart_mmio_pkg;

    localparam logic [3:0] ADDR_DATA   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_CTRL   = 4'h8;

    localparam int DATA_VALID     = 8;

    localparam int STAT_EMPTY     = 8;
    localparam int STAT_FULL      = 9;
    localparam int STAT_OVERRUN   = 10;
    localparam int STAT_IRQ_MASK  = 11;

    localparam int CTRL_FLUSH     = 0;
    localparam int CTRL_CLR_OVR   = 1;
    localparam int CTRL_IRQ_MASK  = 2;

    // state    | meaning
    // ST_IDLE  | waiting for bus_valid; request and side effects taken here
    // ST_RESP  | bus_ready=1 with registered bus_rdata, back to idle next cycle
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } bus_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/pop/flush and a level counter one bit wider than
// the pointers so that full and empty are distinguishable. A pop on empty and a
// push on full (without a simultaneous pop) are ignored; flush overrides both.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Pointer and level bookkeeping; flush returns everything to the empty state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      level_q <= level_q + (AW+1)'(1);
            else if (do_pop && !do_push) level_q <= level_q - (AW+1)'(1);
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_rx_mmio.sv
// Memory-mapped receive buffer between uart_rx and the core data bus.
// Registers: 0x0 DATA (read pops), 0x4 STATUS, 0x8 CTRL (flush / clear overrun).
// Optional feature macro UART_RX_MMIO_IRQ_EN: level interrupt with CTRL bit2 mask,
// mask visible in STATUS[11]. Without it irq is tied low.
module uart_rx_mmio
    import uart_mmio_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_dv,
    input  logic [7:0]  rx_byte,
    input  logic        bus_valid,
    input  logic        bus_we,
    input  logic [3:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ready,
    output logic        irq
);

    bus_state_e  state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic        overrun_q, overrun_d;
    logic        irq_mask_q;

    logic        pop;
    logic        flush;
    logic        clr_ovr;
    logic        ctrl_wr;
    logic        ovr_set;
    logic [31:0] status_w;

    logic [7:0]  fifo_head;
    logic        fifo_full;
    logic        fifo_empty;
    logic [AW:0] fifo_level;

    logic        unused_wdata;
    assign unused_wdata = ^bus_wdata[31:2];

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (rx_dv & ~flush),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (rx_byte),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // STATUS word assembled from live FIFO flags and sticky state.
    always_comb begin
        status_w                = '0;
        status_w[7:0]           = 8'(fifo_level);
        status_w[STAT_EMPTY]    = fifo_empty;
        status_w[STAT_FULL]     = fifo_full;
        status_w[STAT_OVERRUN]  = overrun_q;
        status_w[STAT_IRQ_MASK] = irq_mask_q;
    end

    // Bus FSM next state, read data and the one-shot side effects of a request.
    always_comb begin
        state_d = state_q;
        rdata_d = '0;
        pop     = 1'b0;
        flush   = 1'b0;
        clr_ovr = 1'b0;
        ctrl_wr = 1'b0;
        if (state_q == ST_IDLE) begin
            if (bus_valid) begin
                state_d = ST_RESP;
                if (!bus_we) begin
                    if (bus_addr == ADDR_DATA) begin
                        if (!fifo_empty) begin
                            rdata_d = {23'b0, 1'b1, fifo_head};
                            pop     = 1'b1;
                        end
                    end else if (bus_addr == ADDR_STATUS) begin
                        rdata_d = status_w;
                    end
                end else if (bus_addr == ADDR_CTRL) begin
                    ctrl_wr = 1'b1;
                    flush   = bus_wdata[CTRL_FLUSH];
                    clr_ovr = bus_wdata[CTRL_CLR_OVR];
                end
            end
        end else begin
            state_d = ST_IDLE;
        end
    end

    // Overrun is sticky; a byte dropped in the same cycle as a clear keeps it set.
    always_comb begin
        ovr_set   = rx_dv & fifo_full & ~pop & ~flush;
        overrun_d = overrun_q;
        if (clr_ovr) overrun_d = 1'b0;
        if (ovr_set) overrun_d = 1'b1;
    end

    // FSM state, response data and overrun registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rdata_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rdata_q   <= rdata_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus_ready = (state_q == ST_RESP);
    assign bus_rdata = rdata_q;

`ifdef UART_RX_MMIO_IRQ_EN
    logic irq_mask_d;
    logic irq_q, irq_d;

    // Mask follows CTRL bit2 on every CTRL write; irq lags its causes by one cycle.
    always_comb begin
        irq_mask_d = ctrl_wr ? bus_wdata[CTRL_IRQ_MASK] : irq_mask_q;
        irq_d      = ((fifo_level != '0) | overrun_q) & ~irq_mask_q;
    end

    // Interrupt mask and registered interrupt output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_mask_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            irq_mask_q <= irq_mask_d;
            irq_q      <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    logic unused_ctrl_wr;
    assign unused_ctrl_wr = ctrl_wr;
    assign irq_mask_q     = 1'b0;
    assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed bench for uart_rx_mmio (DEPTH=16). Expected values are hand-derived
// register words; build with UART_RX_MMIO_IRQ_EN defined to cover the interrupt.
module tb_uart_rx_mmio;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_dv = 1'b0;
    logic [7:0]  rx_byte = '0;
    logic        bus_valid = 1'b0;
    logic        bus_we = 1'b0;
    logic [3:0]  bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        irq;

    int checks = 0;
    int failures = 0;

`ifdef UART_RX_MMIO_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    uart_rx_mmio #(.DEPTH(16), .AW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_dv     (rx_dv),
        .rx_byte   (rx_byte),
        .bus_valid (bus_valid),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_dv   = 1'b1;
        rx_byte = b;
        @(posedge clk); #1;
        rx_dv   = 1'b0;
    endtask

    // One bus request, optionally with an rx_dv strobe on the same sampling edge.
    task automatic bus_xfer(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                            input logic with_rx, input logic [7:0] rxb, output logic [31:0] rd);
        int lat;
        @(posedge clk); #1;
        bus_valid = 1'b1;
        bus_we    = we;
        bus_addr  = addr;
        bus_wdata = wd;
        if (with_rx) begin
            rx_dv   = 1'b1;
            rx_byte = rxb;
        end
        lat = 0;
        do begin
            @(posedge clk); #1;
            rx_dv = 1'b0;
            lat++;
        end while (!bus_ready && lat < 8);
        check_eq("ready_latency", 32'(lat), 32'd1);
        rd        = bus_rdata;
        bus_valid = 1'b0;
        bus_we    = 1'b0;
        bus_wdata = '0;
    endtask

    task automatic rd_reg(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] r;
        bus_xfer(1'b0, addr, 32'h0, 1'b0, 8'h00, r);
        check_eq(tag, r, exp);
    endtask

    task automatic wr_reg(input logic [3:0] addr, input logic [31:0] wd);
        logic [31:0] r;
        bus_xfer(1'b1, addr, wd, 1'b0, 8'h00, r);
        check_eq("write_rdata", r, 32'h0);
    endtask

    initial begin
        logic [31:0] r;

        // 1: reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(bus_ready), 32'h0);
        check_eq("rst_rdata", bus_rdata, 32'h0);
        check_eq("rst_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        rd_reg("t1_status", 4'h4, 32'h100);
        rd_reg("t1_data", 4'h0, 32'h000);

        // 2: two bytes, plus reserved / CTRL reads and an ignored DATA write
        push_byte(8'h41);
        push_byte(8'h42);
        rd_reg("t2_status", 4'h4, 32'h002);
        rd_reg("t2_resv", 4'hC, 32'h0);
        rd_reg("t2_ctrl_rd", 4'h8, 32'h0);
        wr_reg(4'h0, 32'h99);
        rd_reg("t2_data0", 4'h0, 32'h141);
        rd_reg("t2_data1", 4'h0, 32'h142);
        rd_reg("t2_data2", 4'h0, 32'h000);

        // 3: overflow by one, drain, clear overrun
        for (int i = 0; i < 17; i++) push_byte(8'(i));
        rd_reg("t3_status_ovr", 4'h4, 32'h610);
        for (int i = 0; i < 16; i++) rd_reg($sformatf("t3_data%0d", i), 4'h0, 32'h100 + 32'(i));
        wr_reg(4'h8, 32'h2);
        rd_reg("t3_status_clr", 4'h4, 32'h100);

        // 4: push coincident with pop while full
        for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
        bus_xfer(1'b0, 4'h0, 32'h0, 1'b1, 8'hAA, r);
        check_eq("t4_pop_head", r, 32'h120);
        rd_reg("t4_status", 4'h4, 32'h210);
        for (int i = 1; i < 16; i++) rd_reg($sformatf("t4_data%0d", i), 4'h0, 32'h120 + 32'(i));
        rd_reg("t4_last", 4'h0, 32'h1AA);
        rd_reg("t4_status_end", 4'h4, 32'h100);

        // 5: flush coincident with an incoming byte
        for (int i = 0; i < 5; i++) push_byte(8'h60 + 8'(i));
        rd_reg("t5_status_pre", 4'h4, 32'h005);
        bus_xfer(1'b1, 4'h8, 32'h1, 1'b1, 8'h55, r);
        rd_reg("t5_status", 4'h4, 32'h100);
        rd_reg("t5_data", 4'h0, 32'h000);

        // 6: interrupt, mask and unmask
        check_eq("t6_irq_idle", 32'(irq), 32'h0);
        push_byte(8'h77);
        @(posedge clk); #1;
        check_eq("t6_irq_set", 32'(irq), IRQ_ON ? 32'h1 : 32'h0);
        wr_reg(4'h8, 32'h4);
        @(posedge clk); #1;
        check_eq("t6_irq_masked", 32'(irq), 32'h0);
        rd_reg("t6_status", 4'h4, IRQ_ON ? 32'h801 : 32'h001);
        rd_reg("t6_data", 4'h0, 32'h177);
        wr_reg(4'h8, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("t6_irq_after", 32'(irq), 32'h0);

        // 7: reset during a response drops bus_ready immediately
        push_byte(8'h12);
        @(posedge clk); #1;
        bus_valid = 1'b1;
        bus_we    = 1'b0;
        bus_addr  = 4'h0;
        @(posedge clk); #1;
        check_eq("t7_ready_pre", 32'(bus_ready), 32'h1);
        reset = 1'b1;
        #1;
        check_eq("t7_ready_rst", 32'(bus_ready), 32'h0);
        check_eq("t7_rdata_rst", bus_rdata, 32'h0);
        bus_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        rd_reg("t7_status", 4'h4, 32'h100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
